// File: rtl/adc_result_fifo_if.sv
// Read-side valid/ready port of the ADC result FIFO.
// master = FIFO, slave = consumer.
interface adc_result_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_valid_out;
  logic                  rd_ready_in;

  modport master (
    output rd_data_out,
    output rd_valid_out,
    input  rd_ready_in
  );

  modport slave (
    input  rd_data_out,
    input  rd_valid_out,
    output rd_ready_in
  );
endinterface

// File: rtl/adc_result_fifo.sv
// Circular FWFT FIFO for SAR-ADC results with overflow,
// saturating drop counter and level-threshold interrupt.
module adc_result_fifo #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      data_strobe_in,
  input  logic                      enable_in,
  input  logic                      clear_in,
  adc_result_fifo_if.master         rd,
  output logic [LW-1:0]             level_out,
  output logic                      full_out,
  output logic                      empty_out,
  input  logic [LW-1:0]             thresh_in,
  output logic                      thresh_irq_out,
  output logic                      overflow_out,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_out
);

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      ovf_q, ovf_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      irq_q, irq_d;

  logic push, pop, full, empty, accept, drop;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign push   = data_strobe_in & enable_in;
  assign pop    = ~empty & rd.rd_ready_in;
  // A pop in the same cycle frees the slot for a push at full.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(accept) - LW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
        if (~&drop_q) drop_d = drop_q + 1'b1;
      end
    end
    irq_d = (thresh_in != '0) && (level_d >= thresh_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear_in && accept)
      mem_q[wr_ptr_q] <= data_in;
  end

  assign rd.rd_valid_out = ~empty;
  assign rd.rd_data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_out       = level_q;
  assign full_out        = full;
  assign empty_out       = empty;
  assign thresh_irq_out  = irq_q;
  assign overflow_out    = ovf_q;
  assign drop_cnt_out    = drop_q;

endmodule

// File: tb/tb_adc_result_fifo.sv
// Scoreboard bench for adc_result_fifo: directed pushes queue
// expected words, a negedge monitor checks each accepted read.
module tb_adc_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_strobe_in;
  logic        enable_in;
  logic        clear_in;
  logic [3:0]  level_out;
  logic        full_out;
  logic        empty_out;
  logic [3:0]  thresh_in;
  logic        thresh_irq_out;
  logic        overflow_out;
  logic [7:0]  drop_cnt_out;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  adc_result_fifo_if #(.DATA_WIDTH(16)) rd_if ();

  adc_result_fifo #(
    .DATA_WIDTH(16),
    .DEPTH(8),
    .DROP_CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_strobe_in(data_strobe_in),
    .enable_in(enable_in),
    .clear_in(clear_in),
    .rd(rd_if.master),
    .level_out(level_out),
    .full_out(full_out),
    .empty_out(empty_out),
    .thresh_in(thresh_in),
    .thresh_irq_out(thresh_irq_out),
    .overflow_out(overflow_out),
    .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input bit expect_ok);
    data_in = w;
    data_strobe_in = 1'b1;
    step();
    data_strobe_in = 1'b0;
    if (expect_ok) exp_q.push_back(w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_if.rd_ready_in = 1'b1;
    while (!empty_out && n < 40) begin
      step();
      n++;
    end
    rd_if.rd_ready_in = 1'b0;
    check("drain_empty", 32'(empty_out), 32'd1);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rd_if.rd_valid_out && rd_if.rd_ready_in) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %0h expected none",
                 rd_if.rd_data_out);
      end else begin
        check("rd_data", 32'(rd_if.rd_data_out),
              32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    data_in = '0;
    data_strobe_in = 1'b0;
    enable_in = 1'b0;
    clear_in = 1'b0;
    thresh_in = '0;
    rd_if.rd_ready_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_empty", 32'(empty_out), 32'd1);
    check("rst_full", 32'(full_out), 32'd0);
    check("rst_valid", 32'(rd_if.rd_valid_out), 32'd0);
    check("rst_data", 32'(rd_if.rd_data_out), 32'd0);
    check("rst_level", 32'(level_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_drop", 32'(drop_cnt_out), 32'd0);
    check("rst_irq", 32'(thresh_irq_out), 32'd0);

    // fill
    enable_in = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(16'(i), 1'b1);
    check("fill_full", 32'(full_out), 32'd1);
    check("fill_level", 32'(level_out), 32'd8);
    check("fill_head", 32'(rd_if.rd_data_out), 32'h0001);
    check("fill_irq_off", 32'(thresh_irq_out), 32'd0);

    // overflow
    push_word(16'hAAAA, 1'b0);
    push_word(16'hBBBB, 1'b0);
    push_word(16'hCCCC, 1'b0);
    check("ovf_flag", 32'(overflow_out), 32'd1);
    check("ovf_drop3", 32'(drop_cnt_out), 32'd3);
    check("ovf_level", 32'(level_out), 32'd8);
    drain();

    // saturation
    for (int i = 1; i <= 8; i++) push_word(16'h0100 + 16'(i), 1'b1);
    data_in = 16'hDEAD;
    data_strobe_in = 1'b1;
    for (int i = 0; i < 300; i++) step();
    data_strobe_in = 1'b0;
    check("sat_drop", 32'(drop_cnt_out), 32'd255);
    drain();

    // clear
    for (int i = 1; i <= 5; i++) push_word(16'h0200 + 16'(i), 1'b1);
    check("clr_pre_level", 32'(level_out), 32'd5);
    check("clr_pre_ovf", 32'(overflow_out), 32'd1);
    clear_in = 1'b1;
    push_word(16'h0999, 1'b0);
    clear_in = 1'b0;
    exp_q.delete();
    check("clr_level", 32'(level_out), 32'd0);
    check("clr_empty", 32'(empty_out), 32'd1);
    check("clr_ovf", 32'(overflow_out), 32'd0);
    check("clr_drop", 32'(drop_cnt_out), 32'd0);
    check("clr_valid", 32'(rd_if.rd_valid_out), 32'd0);

    // full push+pop
    for (int i = 1; i <= 8; i++) push_word(16'(i), 1'b1);
    rd_if.rd_ready_in = 1'b1;
    push_word(16'h1234, 1'b1);
    rd_if.rd_ready_in = 1'b0;
    check("fpp_level", 32'(level_out), 32'd8);
    check("fpp_ovf", 32'(overflow_out), 32'd0);
    check("fpp_head", 32'(rd_if.rd_data_out), 32'h0002);
    drain();

    // wrap-around
    push_word(16'h5000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rd_if.rd_ready_in = (i % 4 != 0);
      if (i % 4 != 3) push_word(16'h5001 + 16'(i), 1'b1);
      else step();
    end
    rd_if.rd_ready_in = 1'b0;
    check("wrap_level", 32'(level_out), 32'd1);
    drain();

    // threshold
    thresh_in = 4'd4;
    for (int i = 1; i <= 3; i++) push_word(16'h0300 + 16'(i), 1'b1);
    check("irq_below", 32'(thresh_irq_out), 32'd0);
    push_word(16'h0304, 1'b1);
    check("irq_high", 32'(thresh_irq_out), 32'd1);
    rd_if.rd_ready_in = 1'b1;
    step();
    rd_if.rd_ready_in = 1'b0;
    check("irq_low", 32'(thresh_irq_out), 32'd0);

    // enable low
    enable_in = 1'b0;
    push_word(16'h0EEE, 1'b0);
    push_word(16'h0EEF, 1'b0);
    check("en_level", 32'(level_out), 32'd3);
    thresh_in = 4'd0;
    step();
    check("irq_disabled", 32'(thresh_irq_out), 32'd0);
    thresh_in = 4'd3;
    step();
    check("irq_reen", 32'(thresh_irq_out), 32'd1);
    thresh_in = 4'd0;
    step();
    check("irq_off_again", 32'(thresh_irq_out), 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_result_fifo.md
Name: adc_result_fifo

Overview:
- Buffers conversion results from the SAR-ADC digital core, downstream of it, so a slower consumer can drain them without losing samples.
- Each result is captured on the core's one-cycle conversion-finished strobe and pushed into a circular FIFO.
- Results are presented first-word-fall-through on a valid/ready read port.
- Also provides level, full/empty, a sticky overflow flag, a saturating drop counter and a level-threshold interrupt.

Parameters:
- DATA_WIDTH, 16, width of one result word; matches the core's result bus.
- DEPTH, 8, number of FIFO entries; must be a power of two and at least 2.
- DROP_CNT_WIDTH, 8, width of the saturating dropped-sample counter.

Ports:
- clk  in  1  digital clock, same domain as the ADC core's digital clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  result word from the ADC core.
- data_strobe_in  in  1  one-cycle pulse; data_in is valid this cycle.
- enable_in  in  1  capture enable; strobes are ignored while low.
- clear_in  in  1  synchronous flush of FIFO contents and status.
- rd_data_out  out  DATA_WIDTH  head-of-FIFO word.
- rd_valid_out  out  1  rd_data_out holds a valid word.
- rd_ready_in  in  1  consumer accepts the word.
- level_out  out  $clog2(DEPTH)+1  number of stored words.
- full_out  out  1  level_out == DEPTH.
- empty_out  out  1  level_out == 0.
- thresh_in  in  $clog2(DEPTH)+1  interrupt threshold.
- thresh_irq_out  out  1  level threshold reached.
- overflow_out  out  1  sticky: a sample was dropped.
- drop_cnt_out  out  DROP_CNT_WIDTH  saturating count of dropped samples.

Behaviour:
- Reset, when rst is high at a clk edge:
  - read and write pointers, level, overflow, drop count and irq all go to 0.
  - empty_out=1, full_out=0, rd_valid_out=0, rd_data_out=0.
  - Memory contents are don't-care.
- Push condition: push = data_strobe_in & enable_in.
  - A push with no pop is accepted only when not full.
  - The word is written at wr_ptr, wr_ptr increments modulo DEPTH, and level increments.
- Pop condition: pop = rd_valid_out & rd_ready_in.
  - rd_ptr increments modulo DEPTH and level decrements.
- rd_valid_out equals !empty_out, registered state, with no combinational path from inputs.
- rd_data_out is always mem[rd_ptr]; it is 0 when empty.
- Latency and bypass:
  - A push into an empty FIFO at edge N makes rd_valid_out high after edge N. No same-cycle bypass.
  - Push and pop in the same cycle leave level unchanged.
- Full with simultaneous push and pop: the push is accepted (the slot is freed this cycle), no overflow, level stays DEPTH.
- Full with push and no pop:
  - The new word is discarded and stored data is unchanged.
  - overflow_out is set.
  - drop_cnt_out increments, saturating at all-ones.
- Empty with pop: impossible by construction, since rd_valid_out is 0.
- clear_in has priority over push and pop in the same cycle.
  - Pointers, level, overflow_out and drop_cnt_out are zeroed.
  - A push in the clear cycle is discarded and not counted.
- Mid-operation reset or clear: state is fully reinitialised next cycle; no partial words survive.
- Threshold interrupt:
  - thresh_irq_out is registered: high the cycle after next_level >= thresh_in with thresh_in != 0.
  - thresh_in == 0 disables it (forced 0).
  - It deasserts on the edge where next_level drops below thresh_in.
  - It is level-sensitive, not sticky.
- Pointer and level arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Level uses one extra bit so that DEPTH is representable.
- full_out and empty_out are derived from the registered level.
- enable_in low does not block reads; the FIFO can still drain.

Test Plan:
- Fill then drain: reset, enable=1, push 0x0001..0x0008 with rd_ready=0 → full_out=1, level=8. Then rd_ready=1 → words read out 0x0001..0x0008 in order, empty_out=1 at the end.
- Overflow: at full, push 3 more (0xAAAA, 0xBBBB, 0xCCCC) → overflow_out=1, drop_cnt_out=3, and the drained data is still 0x0001..0x0008. Then 300 drops → drop_cnt_out saturates at 255.
- Full push+pop: at full with head 0x0001, push 0x1234 with rd_ready=1 → 0x0001 consumed, level stays 8, no overflow, 0x1234 is the last word read.
- Wrap-around: 20 interleaved push/pop cycles with level kept between 1 and 3 → every word is read back in order across pointer wrap.
- Clear: level=5 with overflow set, assert clear_in together with a push → next cycle level=0, empty_out=1, overflow_out=0, drop_cnt_out=0, rd_valid_out=0.
- Threshold and enable: thresh_in=4, push 4 words → irq high the cycle after the 4th push; pop one → irq low after that edge. enable_in=0 with strobes → level unchanged. thresh_in=0 → irq stays low.
